// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and data requesters.
// It runs a registered req/ready handshake and returns read data with one-cycle done pulses.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t              state, state_nx;
  logic [3:0]          streak, streak_nx;
  logic                m_req_nx, m_wr_nx;
  logic [ADDR_W-1:0]   m_addr_nx;
  logic [31:0]         m_wdata_nx, i_rdata_nx, d_rdata_nx;
  logic                i_done_nx, d_done_nx;
  logic                i_elig, d_elig, grant_d, grant_i, turnaround;

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      streak  <= streak_nx;
      m_req   <= m_req_nx;
      m_wr    <= m_wr_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      i_rdata <= i_rdata_nx;
      d_rdata <= d_rdata_nx;
      i_done  <= i_done_nx;
      d_done  <= d_done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    streak_nx  = streak;
    m_req_nx   = m_req;
    m_wr_nx    = m_wr;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    i_rdata_nx = i_rdata;
    d_rdata_nx = d_rdata;
    i_done_nx  = 1'b0;
    d_done_nx  = 1'b0;

    i_elig  = i_req & ~i_done;
    d_elig  = d_req & ~d_done;
    grant_d = d_elig & (~i_elig | (streak < MAX_S));
    grant_i = i_elig & ~grant_d;
    // The done cycle is the mandatory turnaround: no grant to either side.
    turnaround = i_done | d_done;

    case (state)
      IDLE: begin
        if (!turnaround) begin
          if (grant_d) begin
            state_nx   = D_BUSY;
            m_req_nx   = 1'b1;
            m_wr_nx    = d_wr;
            m_addr_nx  = d_addr;
            m_wdata_nx = d_wdata;
            if (i_req)
              streak_nx = (streak == 4'hF) ? streak : streak + 4'd1;
            else
              streak_nx = '0;
          end else if (grant_i) begin
            state_nx  = I_BUSY;
            m_req_nx  = 1'b1;
            m_wr_nx   = 1'b0;
            m_addr_nx = i_addr;
            streak_nx = '0;
          end
        end
      end
      I_BUSY: begin
        if (m_ready) begin
          state_nx   = IDLE;
          m_req_nx   = 1'b0;
          m_wr_nx    = 1'b0;
          i_done_nx  = 1'b1;
          i_rdata_nx = m_rdata;
        end
      end
      D_BUSY: begin
        if (m_ready) begin
          state_nx  = IDLE;
          m_req_nx  = 1'b0;
          m_wr_nx   = 1'b0;
          d_done_nx = 1'b1;
          if (!m_wr) d_rdata_nx = m_rdata;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported backing memory between the processor's instruction-fetch port and data-access port. Each side raises a level request. The arbiter grants one request at a time, latches its address and data, and runs a req/ready handshake to the memory. It then returns read data with a one-cycle done pulse. The stall outputs feed the fetch stage and the hazards controller as `icache_stall` and `dcache_stall`.

## Interface
- `MAX_D_STREAK`, default 4: number of consecutive data grants allowed while a fetch request waits; the next grant then goes to fetch. Range 1–15.
- `ADDR_W`, default 32: address width.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low (0 = reset).
- `i_req` input 1: fetch request, level; held until `i_done`.
- `i_addr` input ADDR_W: fetch address; sampled only on grant.
- `i_rdata` output 32: registered fetch read data.
- `i_done` output 1: one-cycle completion pulse for fetch.
- `i_stall` output 1: `i_req & ~i_done`.
- `d_req` input 1: data request, level; held until `d_done`.
- `d_wr` input 1: 1 = write, 0 = read; sampled on grant.
- `d_addr` input ADDR_W: data address; sampled on grant.
- `d_wdata` input 32: write data; sampled on grant.
- `d_rdata` output 32: registered data read data.
- `d_done` output 1: one-cycle completion pulse for data.
- `d_stall` output 1: `d_req & ~d_done`.
- `m_req` output 1: memory request, registered.
- `m_wr` output 1: memory write enable, registered.
- `m_addr` output ADDR_W: memory address, registered.
- `m_wdata` output 32: memory write data, registered.
- `m_ready` input 1: memory completion, sampled while `m_req` = 1.
- `m_rdata` input 32: memory read data, valid when `m_ready` = 1.

## Operation
- States: IDLE, I_BUSY, D_BUSY. Reset state is IDLE.
- **Reset values:** `m_req`, `m_wr`, `i_done` and `d_done` are 0. `m_addr`, `m_wdata`, `i_rdata` and `d_rdata` are 0. The streak counter is 0.
- **Arbitration in IDLE:** a requester is eligible when its req = 1 and its done = 0 in that cycle. The done mask prevents a re-grant to a requester that has not yet dropped req.
  - Only one side eligible: grant that side.
  - Both eligible: grant data, unless streak ≥ `MAX_D_STREAK`, in which case grant fetch.
- **Grant:** go to I_BUSY or D_BUSY on the next edge. At that edge, load `m_req`=1, `m_addr`, and for data also `m_wr`=`d_wr` and `m_wdata`=`d_wdata`. A fetch grant sets `m_wr`=0.
- **Busy:** while `m_ready`=0, hold every `m_*` output stable. Changes on the requester inputs are ignored.
- **Completion (edge with `m_ready`=1 in a busy state):**
  - Clear `m_req` and `m_wr`; return to IDLE.
  - Pulse the granted side's done for exactly one cycle.
  - On reads, load that side's rdata from `m_rdata`. On writes, `d_rdata` is unchanged.
- **Streak counter** (4 bits, saturating at 15):
  - Data grant while `i_req`=1: increment.
  - Data grant while `i_req`=0: clear to 0.
  - Any fetch grant: clear to 0.
- **Requester drops req mid-transaction:** the transaction still completes and done still pulses. The requester ignores the pulse.
- **Write then read of the same address:** ordering follows grant order; there is no reordering or forwarding.
- **Reset asserted mid-transaction:** go immediately to IDLE and return all outputs to their reset values. The memory must tolerate `m_req` dropping without `m_ready`.

## Timing
- Minimum latency with `m_ready` tied to 1:
  - Cycle 0: req rises.
  - Cycle 1: `m_req`=1.
  - Cycle 2: done=1 and rdata valid.
  - Stall is high for cycles 0–1.
- General latency: 2 + W cycles, where W is the number of busy cycles with `m_ready`=0.
- Turnaround: at least one IDLE cycle between transactions. A losing requester therefore waits the winner's full latency plus one cycle.
- `i_stall` and `d_stall` are combinational from req and done. They are low in the done cycle so the pipeline advances.
- rdata holds its value until the next read completion for that side.

## Test plan
- **Single fetch:** `m_ready`=1, `i_req`=1 at cycle 0 with `i_addr`=0x100 and `m_rdata`=0xDEADBEEF.
  - Required: cycle 1 `m_req`=1, `m_addr`=0x100, `m_wr`=0.
  - Required: cycle 2 `i_done`=1, `i_rdata`=0xDEADBEEF, `i_stall`=0.
- **Simultaneous requests:** `i_req` and `d_req` both rise at cycle 0; data is a write with `d_addr`=0x40 and `d_wdata`=5.
  - Required: data granted first (`m_wr`=1, `m_wdata`=5), `d_done` at cycle 2.
  - Required: fetch granted at cycle 3, `i_done` at cycle 5.
- **Starvation guard:** `MAX_D_STREAK`=4, `d_req` and `i_req` held high continuously, `d_req` re-raised each time.
  - Required: grant order is D, D, D, D, I, D, and so on.
- **Wait states:** `m_ready` held low for 3 cycles on a data read of 0x80.
  - Required: `m_addr` stays 0x80 throughout, even though `d_addr` changes on cycle 2.
  - Required: `d_done` at cycle 5, exactly one cycle wide.
- **Reset mid-transaction:** `rst`=0 asserted during D_BUSY.
  - Required: `m_req`=0 immediately (asynchronous), no done pulse, state IDLE after release.
  - Required: a new fetch after release completes normally.
- **Requester drops req:** `i_req` deasserted during I_BUSY.
  - Required: `i_done` still pulses once; no second grant follows.
